// File: rtl/knn_query_controller.sv
// Sequences one k-NN query: clears the top-5 sorter, streams every training sample
// through the distance engine into the sorter, then majority-votes the 5 nearest entries.
//
// state   | meaning
// IDLE    | waiting for start
// CLEAR   | sorter clear pulse, sample address reset
// FETCH   | sample memory read at mem_addr
// LAUNCH  | distance engine launch, label captured
// WAIT_DE | waiting for engine result, timeout armed
// INSERT  | sorter insert of distance + label
// SETTLE  | sorter registers update
// VOTE    | majority vote over sorter contents
// FINISH  | done pulse
module knn_query_controller #(
  parameter int N_SAMPLES = 64,
  parameter int ADDR_W    = 6,
  parameter int TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        class_out,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_label,
  output logic              de_start,
  input  logic              de_done,
  output logic              sort_clr,
  output logic              sort_valid,
  output logic [1:0]        sort_label,
  input  logic [99:0]       sorted_list
);

  typedef enum logic [3:0] {
    IDLE, CLEAR, FETCH, LAUNCH, WAIT_DE, INSERT, SETTLE, VOTE, FINISH
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);
  localparam logic [9:0]        TO_LAST   = 10'(TIMEOUT - 1);
  localparam logic [17:0]       MAX_DIST  = 18'h3FFFF;

  state_t     state, state_nx;
  logic [9:0] to_cnt;
  logic       to_hit;

  logic [2:0] cls_cnt [4];
  logic [4:0] ent_valid;
  logic [1:0] ent_cls [5];
  logic [2:0] best_cnt;
  logic [1:0] vote_class;
  logic       any_valid;

  assign to_hit = (to_cnt == TO_LAST);

  // Vote: ranks are scanned nearest-first with a strict compare, so a tie resolves
  // to the class that appears at the lowest rank.
  always_comb begin
    for (int c = 0; c < 4; c++) cls_cnt[c] = '0;
    ent_valid  = '0;
    best_cnt   = '0;
    vote_class = '0;
    any_valid  = 1'b0;
    for (int r = 0; r < 5; r++) begin
      ent_cls[r]   = sorted_list[20*r +: 2];
      ent_valid[r] = (sorted_list[20*r+2 +: 18] != MAX_DIST);
      if (ent_valid[r]) begin
        cls_cnt[ent_cls[r]] = cls_cnt[ent_cls[r]] + 3'd1;
        any_valid = 1'b1;
      end
    end
    for (int r = 0; r < 5; r++) begin
      if (ent_valid[r] && (cls_cnt[ent_cls[r]] > best_cnt)) begin
        best_cnt   = cls_cnt[ent_cls[r]];
        vote_class = ent_cls[r];
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CLEAR;
      CLEAR:   state_nx = FETCH;
      FETCH:   state_nx = LAUNCH;
      LAUNCH:  state_nx = WAIT_DE;
      WAIT_DE: begin
        if (de_done)     state_nx = INSERT;
        else if (to_hit) state_nx = FINISH;
      end
      INSERT:  state_nx = (mem_addr == LAST_ADDR) ? SETTLE : FETCH;
      SETTLE:  state_nx = VOTE;
      VOTE:    state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      mem_addr   <= '0;
      sort_label <= '0;
      error      <= 1'b0;
      class_out  <= '0;
      to_cnt     <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE:    if (start) error <= 1'b0;
        CLEAR:   mem_addr <= '0;
        LAUNCH: begin
          sort_label <= mem_label;
          to_cnt     <= '0;
        end
        WAIT_DE: begin
          if (!de_done) begin
            to_cnt <= to_cnt + 10'd1;
            if (to_hit) error <= 1'b1;
          end
        end
        INSERT:  if (mem_addr != LAST_ADDR) mem_addr <= mem_addr + ADDR_W'(1);
        VOTE: begin
          class_out <= vote_class;
          if (!any_valid) error <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // sort_clr follows rst combinationally so the sorter clears together with us.
  assign sort_clr   = (state == CLEAR) || !rst;
  assign mem_rd_en  = (state == FETCH);
  assign de_start   = (state == LAUNCH);
  assign sort_valid = (state == INSERT);
  assign done       = (state == FINISH);
  assign busy       = (state != IDLE) && (state != FINISH);

endmodule

// File: tb/tb_knn_query_controller.sv
// Directed bench for knn_query_controller with behavioural sample memory,
// fixed-latency distance engine and top-5 insertion sorter.
`timescale 1ns/1ps
module tb_knn_query_controller;

  localparam int          N   = 8;
  localparam int          AW  = 6;
  localparam int          TO  = 20;
  localparam int          L   = 4;
  localparam logic [17:0] MX  = 18'h3FFFF;
  localparam logic [99:0] EMPTY = {5{18'h3FFFF, 2'b00}};

  logic          clk = 1'b0;
  logic          rst, start;
  logic          busy, done, error;
  logic [1:0]    class_out;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_label = '0;
  logic          de_start, de_done;
  logic          sort_clr, sort_valid;
  logic [1:0]    sort_label;
  logic [99:0]   sorted_list = EMPTY;

  int n_checks = 0;
  int n_pass   = 0;

  logic [17:0] dist_tab [64];
  logic [1:0]  lab_tab  [64];
  int          hold_addr = -1;
  int          de_cnt = 0;
  int          de_addr = 0;
  logic [17:0] de_dist = '0;

  int excl_viol = 0;
  int fetch_total = 0, fetch_base = 0, fetch_err = 0;
  int done_count = 0;

  knn_query_controller #(.N_SAMPLES(N), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
    .class_out(class_out), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_label(mem_label), .de_start(de_start), .de_done(de_done),
    .sort_clr(sort_clr), .sort_valid(sort_valid), .sort_label(sort_label),
    .sorted_list(sorted_list)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [99:0] sorter_ins(input logic [99:0] cur, input logic [17:0] d,
                                             input logic [1:0] l);
    logic [99:0] res;
    int pos;
    pos = 5;
    for (int i = 4; i >= 0; i--) if (d < cur[20*i+2 +: 18]) pos = i;
    res = cur;
    for (int i = 0; i < 5; i++) begin
      if (i == pos)     res[20*i +: 20] = {d, l};
      else if (i > pos) res[20*i +: 20] = cur[20*(i-1) +: 20];
    end
    return res;
  endfunction

  // Sample memory, distance engine and sorter models
  always @(posedge clk) if (mem_rd_en) mem_label <= lab_tab[mem_addr];

  always @(posedge clk) begin
    if (de_start) begin
      de_cnt  <= L;
      de_dist <= dist_tab[mem_addr];
      de_addr <= int'(mem_addr);
    end else if (de_cnt != 0) begin
      de_cnt <= de_cnt - 1;
    end
  end
  assign de_done = (de_cnt == 1) && (de_addr != hold_addr);

  always @(posedge clk) begin
    if (sort_clr)        sorted_list <= EMPTY;
    else if (sort_valid) sorted_list <= sorter_ins(sorted_list, de_dist, sort_label);
  end

  always @(negedge clk) begin
    if (rst) begin
      if ((int'(sort_clr) + int'(sort_valid) + int'(de_start) + int'(mem_rd_en)) > 1)
        excl_viol++;
      if (mem_rd_en) begin
        if (int'(mem_addr) != fetch_total - fetch_base) fetch_err++;
        fetch_total++;
      end
    end
    if (done) done_count++;
  end

  task automatic load(input logic [8*18-1:0] d, input logic [15:0] l);
    for (int i = 0; i < 64; i++) begin
      dist_tab[i] = MX;
      lab_tab[i]  = '0;
    end
    for (int i = 0; i < N; i++) begin
      dist_tab[i] = d[(N-1-i)*18 +: 18];
      lab_tab[i]  = l[(N-1-i)*2 +: 2];
    end
  endtask

  task automatic do_query(input string nm, input bit spam, input int exp_lat,
                          input int exp_cls, input int exp_err, input int exp_fetch);
    int   lat, ferr0;
    bit   got;
    logic b1, e1;
    fetch_base = fetch_total;
    ferr0 = fetch_err;
    lat = 0; got = 0; b1 = 0; e1 = 1;
    @(negedge clk);
    start = 1'b1;
    while (!got && lat < 300) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        b1 = busy;
        e1 = error;
      end
      if (done) got = 1;
      else      start = spam & lat[0];
    end
    start = spam;
    check({nm, ".done_seen"}, int'(got), 1);
    check({nm, ".latency"}, lat, exp_lat);
    check({nm, ".busy_after_start"}, int'(b1), 1);
    check({nm, ".error_cleared"}, int'(e1), 0);
    check({nm, ".busy_at_done"}, int'(busy), 0);
    check({nm, ".error"}, int'(error), exp_err);
    if (exp_cls >= 0) check({nm, ".class"}, int'(class_out), exp_cls);
    check({nm, ".fetches"}, fetch_total - fetch_base, exp_fetch);
    check({nm, ".fetch_order"}, fetch_err - ferr0, 0);
    @(negedge clk);
    start = 1'b0;
    check({nm, ".done_one_cycle"}, int'(done), 0);
    @(negedge clk);
    check({nm, ".idle_after"}, int'(busy), 0);
  endtask

  initial begin
    int dc0;
    rst = 1'b0;
    start = 1'b0;
    load({8{MX}}, 16'h0);
    repeat (3) @(negedge clk);
    check("rst.busy", int'(busy), 0);
    check("rst.done", int'(done), 0);
    check("rst.error", int'(error), 0);
    check("rst.class", int'(class_out), 0);
    check("rst.addr", int'(mem_addr), 0);
    check("rst.strobes", int'({mem_rd_en, de_start, sort_valid}), 0);
    check("rst.sort_clr", int'(sort_clr), 1);
    rst = 1'b1;
    @(negedge clk);
    check("idle.sort_clr", int'(sort_clr), 0);

    // nearest five: 10(2) 20(2) 30(1) 40(1) 50(2)
    load({18'd90, 18'd10, 18'd50, 18'd20, 18'd70, 18'd30, 18'd60, 18'd40},
         {2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd1, 2'd0, 2'd1});
    do_query("basic", 0, 60, 2, 0, 8);

    load({18'd10, 18'd20, 18'd30, 18'd40, 18'd50, 18'd60, 18'd70, 18'd80},
         {2'd3, 2'd1, 2'd1, 2'd3, 2'd0, 2'd2, 2'd2, 2'd2});
    do_query("tie3", 0, 60, 3, 0, 8);
    load({18'd10, 18'd20, 18'd30, 18'd40, 18'd50, 18'd60, 18'd70, 18'd80},
         {2'd1, 2'd3, 2'd3, 2'd1, 2'd0, 2'd2, 2'd2, 2'd2});
    do_query("tie1", 0, 60, 1, 0, 8);

    load({18'd10, 18'd20, 18'd30, MX, MX, MX, MX, MX},
         {2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0});
    do_query("three_valid", 0, 60, 0, 0, 8);
    // empty slots carry class 0 and must not outvote the two class-1 entries
    load({18'd30, 18'd10, 18'd20, MX, MX, MX, MX, MX},
         {2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0});
    do_query("max_not_counted", 0, 60, 1, 0, 8);
    load({8{MX}}, 16'h0);
    do_query("none_valid", 0, 60, 0, 1, 8);

    load({18'd90, 18'd10, 18'd50, 18'd20, 18'd70, 18'd30, 18'd60, 18'd40},
         {2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd1, 2'd0, 2'd1});
    hold_addr = 2;
    do_query("timeout", 0, 3 + 2*(L+3) + TO + 1, -1, 1, 3);
    hold_addr = -1;
    do_query("recover", 0, 60, 2, 0, 8);
    do_query("start_spam", 1, 60, 2, 0, 8);

    // reset inside WAIT_DE of sample 2 (label 2 already latched)
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
    dc0 = done_count;
    check("midrst.in_wait_addr", int'(mem_addr), 2);
    rst = 1'b0;
    #1;
    check("midrst.sort_clr_comb", int'(sort_clr), 1);
    @(posedge clk);
    #1;
    check("midrst.busy", int'(busy), 0);
    check("midrst.done", int'(done), 0);
    check("midrst.error", int'(error), 0);
    check("midrst.class", int'(class_out), 0);
    check("midrst.addr", int'(mem_addr), 0);
    check("midrst.sort_label", int'(sort_label), 0);
    check("midrst.strobes", int'({mem_rd_en, de_start, sort_valid}), 0);
    check("midrst.sort_clr", int'(sort_clr), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst.no_done", done_count - dc0, 0);
    do_query("after_rst", 0, 60, 2, 0, 8);

    check("strobe_exclusive", excl_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
